// File: rtl/gate_sweep_sequencer_if.sv
// Bundle of the start/busy/done control bus and the datapath stimulus and
// return lines. The design takes the slave side.
interface gate_sweep_sequencer_if;
  logic       start;
  logic [1:0] sel_mode;
  logic       x;
  logic       y;
  logic       s;
  logic       a_in;
  logic       b_in;
  logic       z_in;
  logic       busy;
  logic       done;
  logic [3:0] or_vec;
  logic [3:0] nor_vec;
  logic [3:0] mux_vec;
  logic       err;

  // Requester and datapath side: issues start, returns the gate outputs.
  modport master (
    output start, sel_mode, a_in, b_in, z_in,
    input  x, y, s, busy, done, or_vec, nor_vec, mux_vec, err
  );

  // Sequencer side.
  modport slave (
    input  start, sel_mode, a_in, b_in, z_in,
    output x, y, s, busy, done, or_vec, nor_vec, mux_vec, err
  );
endinterface

// File: rtl/gate_sweep_sequencer.sv
// Walks the OR/NOR gate unit and its select mux through the four {x,y}
// combinations, captures the returned truth tables and flags any sample that
// disagrees with the ideal gate behaviour. x, y and s are registered so the
// datapath never sees decode glitches.
module gate_sweep_sequencer #(
  parameter int SETTLE = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  gate_sweep_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] mode, mode_nxt;
  logic       x_q, x_nxt;
  logic       y_q, y_nxt;
  logic       s_q, s_nxt;
  logic       busy_q, busy_nxt;
  logic       done_q, done_nxt;
  logic [3:0] or_q, or_nxt;
  logic [3:0] nor_q, nor_nxt;
  logic [3:0] mux_q, mux_nxt;
  logic       err_q, err_nxt;

  // Mux select for vector i under the latched policy; x^y equals i[1]^i[0].
  function automatic logic sel_for(input logic [1:0] m, input logic [1:0] i);
    case (m)
      2'b00:   sel_for = 1'b0;
      2'b01:   sel_for = 1'b1;
      2'b10:   sel_for = ~i[0];
      default: sel_for = i[1] ^ i[0];
    endcase
  endfunction

  // State, counters and all output registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= 2'd0;
      cnt    <= 4'd0;
      mode   <= 2'b00;
      x_q    <= 1'b0;
      y_q    <= 1'b0;
      s_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      or_q   <= 4'b0000;
      nor_q  <= 4'b0000;
      mux_q  <= 4'b0000;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      mode   <= mode_nxt;
      x_q    <= x_nxt;
      y_q    <= y_nxt;
      s_q    <= s_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      or_q   <= or_nxt;
      nor_q  <= nor_nxt;
      mux_q  <= mux_nxt;
      err_q  <= err_nxt;
    end
  end

  // Next state plus the values the output registers take at the coming edge.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    mode_nxt  = mode;
    x_nxt     = 1'b0;
    y_nxt     = 1'b0;
    s_nxt     = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    or_nxt    = or_q;
    nor_nxt   = nor_q;
    mux_nxt   = mux_q;
    err_nxt   = err_q;

    case (state)
      IDLE: begin
        if (bus.start) begin
          mode_nxt  = bus.sel_mode;
          or_nxt    = 4'b0000;
          nor_nxt   = 4'b0000;
          mux_nxt   = 4'b0000;
          err_nxt   = 1'b0;
          idx_nxt   = 2'd0;
          cnt_nxt   = 4'd0;
          state_nxt = RUN;
          busy_nxt  = 1'b1;
          s_nxt     = sel_for(bus.sel_mode, 2'd0);
        end
      end

      RUN: begin
        busy_nxt = 1'b1;
        x_nxt    = x_q;
        y_nxt    = y_q;
        s_nxt    = s_q;
        if (cnt == LAST) begin
          // Last settle cycle of this vector: capture and judge the returns.
          or_nxt[idx]  = bus.a_in;
          nor_nxt[idx] = bus.b_in;
          mux_nxt[idx] = bus.z_in;
          err_nxt = err_q
                  | (bus.a_in != (x_q | y_q))
                  | (bus.b_in != ~(x_q | y_q))
                  | (bus.z_in != (s_q ? bus.a_in : bus.b_in));
          cnt_nxt = 4'd0;
          if (idx == 2'd3) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            x_nxt     = 1'b0;
            y_nxt     = 1'b0;
            s_nxt     = 1'b0;
          end else begin
            idx_nxt = idx + 2'd1;
            x_nxt   = idx_nxt[1];
            y_nxt   = idx_nxt[0];
            s_nxt   = sel_for(mode, idx_nxt);
          end
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.s       = s_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.or_vec  = or_q;
  assign bus.nor_vec = nor_q;
  assign bus.mux_vec = mux_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_gate_sweep_sequencer.sv
// Bench for gate_sweep_sequencer: two instances (SETTLE=1 and SETTLE=3) share
// stimulus; a cycle-count model predicts every output each cycle.
module tb_gate_sweep_sequencer;

  localparam int SV[2] = '{1, 3};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] sel_mode = 2'b00;
  logic       stuck = 1'b0;

  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gate_sweep_sequencer_if bus0 ();
  gate_sweep_sequencer_if bus1 ();

  gate_sweep_sequencer #(.SETTLE(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  gate_sweep_sequencer #(.SETTLE(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Datapath stand-ins: OR (optionally stuck at 0), NOR, and the select mux.
  assign bus0.start    = start;
  assign bus0.sel_mode = sel_mode;
  assign bus0.a_in     = stuck ? 1'b0 : (bus0.x | bus0.y);
  assign bus0.b_in     = ~(bus0.x | bus0.y);
  assign bus0.z_in     = bus0.s ? bus0.a_in : bus0.b_in;
  assign bus1.start    = start;
  assign bus1.sel_mode = sel_mode;
  assign bus1.a_in     = stuck ? 1'b0 : (bus1.x | bus1.y);
  assign bus1.b_in     = ~(bus1.x | bus1.y);
  assign bus1.z_in     = bus1.s ? bus1.a_in : bus1.b_in;

  logic       dx[2], dy[2], ds[2], dbusy[2], ddone[2], derr[2];
  logic [3:0] dor[2], dnor[2], dmux[2];
  assign dx[0] = bus0.x;          assign dx[1] = bus1.x;
  assign dy[0] = bus0.y;          assign dy[1] = bus1.y;
  assign ds[0] = bus0.s;          assign ds[1] = bus1.s;
  assign dbusy[0] = bus0.busy;    assign dbusy[1] = bus1.busy;
  assign ddone[0] = bus0.done;    assign ddone[1] = bus1.done;
  assign derr[0] = bus0.err;      assign derr[1] = bus1.err;
  assign dor[0] = bus0.or_vec;    assign dor[1] = bus1.or_vec;
  assign dnor[0] = bus0.nor_vec;  assign dnor[1] = bus1.nor_vec;
  assign dmux[0] = bus0.mux_vec;  assign dmux[1] = bus1.mux_vec;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference rules, expressed per vector index i = {x,y}.
  function automatic logic sel_of(input logic [1:0] m, input int i);
    case (m)
      2'd0:    return 1'b0;
      2'd1:    return 1'b1;
      2'd2:    return (i % 2) == 0;
      default: return ((i / 2) % 2) != (i % 2);
    endcase
  endfunction
  function automatic logic or_ret(input int i, input logic f);
    return f ? 1'b0 : (i != 0);
  endfunction
  function automatic logic nor_ret(input int i);
    return i == 0;
  endfunction

  // Model: el = cycles elapsed since the accepting start edge (0 = idle).
  // Cycles 1..4S are busy, cycle 4S+1 is the done cycle.
  int         el[2];
  logic [1:0] mm[2];
  logic [3:0] mor[2], mnor[2], mmux[2];
  logic       merr[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        el[k] <= 0; mm[k] <= 2'b00; mor[k] <= 4'b0; mnor[k] <= 4'b0;
        mmux[k] <= 4'b0; merr[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (el[k] == 0) begin
          if (start) begin
            mm[k] <= sel_mode; mor[k] <= 4'b0; mnor[k] <= 4'b0;
            mmux[k] <= 4'b0; merr[k] <= 1'b0; el[k] <= 1;
          end
        end else if (el[k] <= 4 * SV[k]) begin
          if (el[k] % SV[k] == 0) begin
            mor[k][(el[k]-1)/SV[k]]  <= or_ret((el[k]-1)/SV[k], stuck);
            mnor[k][(el[k]-1)/SV[k]] <= nor_ret((el[k]-1)/SV[k]);
            mmux[k][(el[k]-1)/SV[k]] <= sel_of(mm[k], (el[k]-1)/SV[k]) ?
                                        or_ret((el[k]-1)/SV[k], stuck) :
                                        nor_ret((el[k]-1)/SV[k]);
            merr[k] <= merr[k] | (or_ret((el[k]-1)/SV[k], stuck) != ((el[k]-1)/SV[k] != 0));
          end
          el[k] <= el[k] + 1;
        end else begin
          el[k] <= 0;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        automatic bit bz = (el[k] >= 1) && (el[k] <= 4 * SV[k]);
        automatic int vi = bz ? (el[k] - 1) / SV[k] : 0;
        check($sformatf("x%0d", k),    16'(dx[k]),    16'(bz && vi >= 2));
        check($sformatf("y%0d", k),    16'(dy[k]),    16'(bz && (vi % 2) == 1));
        check($sformatf("s%0d", k),    16'(ds[k]),    16'(bz && sel_of(mm[k], vi)));
        check($sformatf("busy%0d", k), 16'(dbusy[k]), 16'(bz));
        check($sformatf("done%0d", k), 16'(ddone[k]), 16'(el[k] == 4 * SV[k] + 1));
        check($sformatf("or%0d", k),   16'(dor[k]),   16'(mor[k]));
        check($sformatf("nor%0d", k),  16'(dnor[k]),  16'(mnor[k]));
        check($sformatf("mux%0d", k),  16'(dmux[k]),  16'(mmux[k]));
        check($sformatf("err%0d", k),  16'(derr[k]),  16'(merr[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start(input logic [1:0] m);
    sel_mode = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // After pulse_start: ride out the four SETTLE=1 vectors, then check the
  // done-cycle results of the SETTLE=1 instance against literals.
  task automatic sweep_check(input string tag, input logic [3:0] e_or,
                             input logic [3:0] e_nor, input logic [3:0] e_mux,
                             input logic e_err);
    idle(4);
    check({tag, "_done"}, 16'(ddone[0]), 16'd1);
    check({tag, "_busy"}, 16'(dbusy[0]), 16'd0);
    check({tag, "_or"},   16'(dor[0]),   16'(e_or));
    check({tag, "_nor"},  16'(dnor[0]),  16'(e_nor));
    check({tag, "_mux"},  16'(dmux[0]),  16'(e_mux));
    check({tag, "_err"},  16'(derr[0]),  16'(e_err));
  endtask

  initial begin
    logic [3:0] s_seq;
    logic [3:0] mux_exp[4];
    mux_exp[0] = 4'b0001; mux_exp[1] = 4'b1110; mux_exp[2] = 4'b0100; mux_exp[3] = 4'b0111;

    idle(2);
    #2 rst_n = 1'b1;
    tick();
    check("rst_outputs", {ds[0], dx[0], dy[0], dbusy[0], ddone[0], derr[0]}, 16'd0);
    check("rst_vecs", {dor[0], dnor[0], dmux[0]}, 16'd0);

    // Alternating select: s = 1,0,1,0 over the four vectors.
    s_seq = 4'b0;
    pulse_start(2'b10);
    for (int j = 0; j < 4; j++) begin
      s_seq[j] = ds[0];
      tick();
    end
    check("alt_s_seq", 16'(s_seq), 16'b0101);
    check("alt_done", 16'(ddone[0]), 16'd1);
    check("alt_or", 16'(dor[0]), 16'b1110);
    check("alt_nor", 16'(dnor[0]), 16'b0001);
    check("alt_mux", 16'(dmux[0]), 16'b0100);
    check("alt_err", 16'(derr[0]), 16'd0);
    tick();
    check("alt_done_once", 16'(ddone[0]), 16'd0);
    idle(14);

    // Other select policies.
    for (int m = 0; m < 4; m++) begin
      if (m == 2) continue;
      pulse_start(2'(m));
      sweep_check($sformatf("mode%0d", m), 4'b1110, 4'b0001, mux_exp[m], 1'b0);
      idle(14);
    end

    // OR output stuck at 0: err rises after vector 1 and is sticky.
    stuck = 1'b1;
    pulse_start(2'b10);
    tick();
    check("fault_err_v0", 16'(derr[0]), 16'd0);
    tick();
    check("fault_err_v1", 16'(derr[0]), 16'd1);
    idle(2);
    check("fault_or", 16'(dor[0]), 16'b0000);
    check("fault_err_done", 16'(derr[0]), 16'd1);
    idle(15);
    check("fault_err_hold", 16'(derr[0]), 16'd1);
    stuck = 1'b0;
    pulse_start(2'b10);
    check("fault_err_clear", 16'(derr[0]), 16'd0);
    idle(16);

    // Reset mid-sweep at vector 2.
    pulse_start(2'b10);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_0", {ds[0], dx[0], dy[0], dbusy[0], ddone[0], derr[0], dor[0], dnor[0]}, 16'd0);
    check("arst_1", {ds[1], dx[1], dy[1], dbusy[1], ddone[1], derr[1], dor[1], dnor[1]}, 16'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(8);
    pulse_start(2'b10);
    sweep_check("post_rst", 4'b1110, 4'b0001, 4'b0100, 1'b0);
    idle(14);

    // Restart requests and mode changes while busy are ignored.
    pulse_start(2'b10);
    for (int j = 0; j < 3; j++) begin
      start = 1'b1;
      sel_mode = 2'($urandom_range(0, 3));
      tick();
    end
    start = 1'b0;
    tick();
    check("ign_done", 16'(ddone[0]), 16'd1);
    check("ign_or", 16'(dor[0]), 16'b1110);
    check("ign_mux", 16'(dmux[0]), 16'b0100);
    tick();
    check("ign_single_done", 16'(ddone[0]), 16'd0);
    idle(14);

    // Random traffic: starts, modes and datapath faults at any time.
    for (int j = 0; j < 400; j++) begin
      start = ($urandom_range(0, 3) == 0);
      sel_mode = 2'($urandom_range(0, 3));
      stuck = ($urandom_range(0, 7) == 0);
      tick();
    end
    start = 1'b0;
    stuck = 1'b0;
    idle(20);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
